// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: run/halt gated cycle, time and hazard-event counters
// with sticky overflow flags, a snapshot shadow bank and a registered read port.
module pipe_perf_monitor #(
   parameter int CNT_W    = 32,
   parameter int N_EVT    = 5,
   parameter int STEP_INC = 20,
   parameter int SATURATE = 1,
   parameter int SEL_W    = 5
) (
   input  logic             i_clk,
   input  logic             i_nrst,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_clr,
   input  logic             i_snap,
   input  logic [N_EVT-1:0] i_evt,
   input  logic [SEL_W-1:0] i_sel,
   input  logic             i_rd_shadow,
   output logic [CNT_W-1:0] o_rd_data,
   output logic [N_EVT+1:0] o_ovf,
   output logic             o_running,
   output logic             o_snap_valid
);

   localparam int NC = N_EVT + 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HALT
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_running;
   logic             r_snap_valid;
   logic [NC-1:0]    r_ovf;
   logic [CNT_W-1:0] r_rd;
   logic [CNT_W-1:0] r_cnt     [NC];
   logic [CNT_W-1:0] r_shd     [NC];
   logic [CNT_W-1:0] w_inc     [NC];
   logic [CNT_W:0]   w_sum     [NC];
   logic [CNT_W-1:0] w_cnt_nxt [NC];
   logic [NC-1:0]    w_carry;
   logic [CNT_W-1:0] w_rd;
   logic             w_count;

   // Clear dominates; a simultaneous start+stop never leaves IDLE/HALT.
   always_comb begin
      w_state_nxt = r_state;
      if (i_clr) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_HALT: begin
               if (i_start && !i_stop) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
               if (i_stop) w_state_nxt = ST_HALT;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_state   <= ST_IDLE;
         r_running <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_running <= (w_state_nxt == ST_RUN);
      end
   end

   assign w_count = (r_state == ST_RUN);

   always_comb begin
      for (int i = 0; i < NC; i++) begin
         w_inc[i] = '0;
      end
      w_inc[0] = CNT_W'(1);
      w_inc[1] = CNT_W'(STEP_INC);
      for (int k = 0; k < N_EVT; k++) begin
         w_inc[k+2] = CNT_W'(i_evt[k]);
      end
      for (int i = 0; i < NC; i++) begin
         w_sum[i]     = {1'b0, r_cnt[i]} + {1'b0, w_inc[i]};
         w_carry[i]   = w_sum[i][CNT_W];
         w_cnt_nxt[i] = (w_carry[i] && SATURATE != 0) ? '1
                                                      : w_sum[i][CNT_W-1:0];
      end
   end

   // Unmapped indices read as zero.
   always_comb begin
      w_rd = '0;
      for (int i = 0; i < NC; i++) begin
         if (i_sel == SEL_W'(i)) begin
            w_rd = i_rd_shadow ? r_shd[i] : r_cnt[i];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         for (int i = 0; i < NC; i++) begin
            r_cnt[i] <= '0;
            r_shd[i] <= '0;
         end
         r_ovf        <= '0;
         r_snap_valid <= 1'b0;
         r_rd         <= '0;
      end else begin
         r_rd <= w_rd;
         if (i_clr) begin
            for (int i = 0; i < NC; i++) begin
               r_cnt[i] <= '0;
               r_shd[i] <= '0;
            end
            r_ovf        <= '0;
            r_snap_valid <= 1'b0;
         end else begin
            if (i_snap) begin
               for (int i = 0; i < NC; i++) begin
                  r_shd[i] <= r_cnt[i];
               end
               r_snap_valid <= 1'b1;
            end
            if (w_count) begin
               for (int i = 0; i < NC; i++) begin
                  r_cnt[i] <= w_cnt_nxt[i];
                  if (w_carry[i]) r_ovf[i] <= 1'b1;
               end
            end
         end
      end
   end

   assign o_rd_data    = r_rd;
   assign o_ovf        = r_ovf;
   assign o_running    = r_running;
   assign o_snap_valid = r_snap_valid;

endmodule

// File: doc/pipe_perf_monitor.md
Name: pipe_perf_monitor

Overview:
- Synthesizable, parametrised cycle and event counter for the MIPS pipeline. It replaces ad-hoc simulation tick and step printing with hardware counters.
- Counts clock ticks, elapsed time steps, and N hazard events: stall, kill1, kill2, forward-A active, forward-B active, and so on.
- Sits beside main_datapath and samples its hazard-unit outputs.
- Provides a run/halt control FSM, a snapshot shadow bank, and an indexed registered read port for bench or debug access.

Parameters:
- CNT_W, 32: width of every counter (min 8).
- N_EVT, 5: number of event inputs and event counters (1..16).
- STEP_INC, 20: amount added to the time counter per counted cycle (clock period in ns).
- SATURATE, 1: 1 = counters stick at all-ones; 0 = counters wrap to 0.
- SEL_W, 5: width of the read index; must satisfy 2^SEL_W >= N_EVT+2.

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_nrst  in  1  asynchronous active-low reset
- i_start  in  1  start/resume counting (level sampled per cycle)
- i_stop  in  1  halt counting
- i_clr  in  1  synchronous clear of all counters, flags and shadows
- i_snap  in  1  copy live counters into shadow bank
- i_evt  in  N_EVT  event strobes, one bit per counter, sampled each cycle
- i_sel  in  SEL_W  read index
- i_rd_shadow  in  1  1 = read shadow bank, 0 = live bank
- o_rd_data  out  CNT_W  registered read data
- o_ovf  out  N_EVT+2  sticky overflow flag per counter (bit0 cycles, bit1 time, bit2+k event k)
- o_running  out  1  FSM in RUN
- o_snap_valid  out  1  shadow bank holds a snapshot taken since last clear/reset

Behaviour:
- Reset (i_nrst=0, asynchronous, takes effect immediately):
  - FSM to IDLE.
  - All live and shadow counters, o_ovf, o_rd_data, o_running and o_snap_valid go to 0.
- FSM states IDLE, RUN, HALT:
  - IDLE->RUN on i_start.
  - RUN->HALT on i_stop.
  - HALT->RUN on i_start.
  - Any state->IDLE on i_clr.
- Priority: i_clr > i_stop > i_start. If start and stop are both high in IDLE or HALT, the FSM stays put. In RUN, both high goes to HALT.
- Counting happens only in cycles where the state is RUN at the rising edge, i.e. the cycle after i_start is seen.
  - cycle counter += 1.
  - time counter += STEP_INC.
  - event counter k += i_evt[k].
  - All counters update in the same edge.
- In IDLE and HALT, counters hold.
- o_running = (state==RUN), registered.
- Overflow:
  - A counter overflows when its increment would exceed 2^CNT_W-1; for the time counter, when the sum carries out.
  - SATURATE=1: the value becomes all-ones and stays there.
  - SATURATE=0: the value takes the low CNT_W bits of the sum.
  - In both modes the matching o_ovf bit sets and stays set until i_clr or reset.
- Clear: i_clr zeroes live counters, shadows, o_ovf and o_snap_valid on the next edge. Any event in that same cycle is discarded.
- Snapshot:
  - On an edge with i_snap=1 (and i_clr=0), the shadow bank takes the live values as they are before that edge's increment. o_snap_valid is set.
  - i_snap is legal in any state.
  - i_snap and i_clr high together: clear wins.
- Read port:
  - Index 0 = cycle counter, 1 = time counter, 2..N_EVT+1 = event counter 0..N_EVT-1. Any other index returns 0.
  - Latency is 1 cycle: o_rd_data on edge n+1 reflects i_sel and i_rd_shadow at edge n, using the bank contents before edge n's update.
- Reset asserted mid-RUN: everything returns to reset values immediately. After release, the FSM requires a fresh i_start.

Test Plan:
- Reset, i_start pulsed 1 cycle, 10 cycles of RUN with i_evt[0]=1 every cycle and i_evt[1]=1 on alternate cycles, then i_stop -> cycles=10, time=200, evt0=10, evt1=5, o_running=0. Counters hold over 5 further idle cycles.
- While RUN, pulse i_snap at cycle 4, continue to cycle 10, then read index 0 with i_rd_shadow=1 and then 0 -> shadow=4, live=10, o_snap_valid=1. Read index N_EVT+5 -> 0.
- CNT_W=8, SATURATE=1, i_evt[0] held high for 300 RUN cycles -> evt0=255, o_ovf[2]=1, o_ovf[0]=1. Time counter=255 and o_ovf[1]=1 after cycle 13.
- Same stimulus with SATURATE=0 -> evt0=300 mod 256=44, cycles=44, o_ovf[2]=1 sticky.
- i_start and i_stop high in the same cycle from IDLE -> stays IDLE, no counts. Then i_clr with i_snap and i_evt all high -> all counters 0, o_snap_valid=0, o_ovf=0.
- Drop i_nrst low for 3 ns mid-RUN, away from clock edges -> outputs 0 immediately. With i_start held low after release, counters stay 0.
